// File: rtl/vend_pkg.sv
// Shared constants for the vending credit path: coin values, display codes, FSM states.
package vend_pkg;

  localparam int NUM_COINS = 4;

  // Coin values in cents, ascending; index 0 is the smallest coin.
  localparam int COIN_VAL [NUM_COINS] = '{5, 10, 25, 100};

  // Display code shown for each coin.
  localparam logic [9:0] COIN_SYM [NUM_COINS] = '{10'd16, 10'd13, 10'd17, 10'd18};

  typedef enum logic {
    IDLE     = 1'b0,
    DISPENSE = 1'b1
  } state_e;

endpackage

// File: rtl/change_picker.sv
// Greedy change selector: the largest coin whose value fits in the remaining credit.
module change_picker
  import vend_pkg::*;
#(
  parameter int N_COIN   = 4,
  parameter int CREDIT_W = 11
) (
  input  logic [CREDIT_W-1:0]       credit_i,
  output logic [$clog2(N_COIN)-1:0] coin_idx_o,
  output logic                      found_o
);

  localparam int IDX_W = $clog2(N_COIN);

  // Coin values ascend with index, so the last fitting coin is the largest.
  always_comb begin
    coin_idx_o = '0;
    found_o    = 1'b0;
    for (int k = 0; k < N_COIN; k++) begin
      if (credit_i >= CREDIT_W'(COIN_VAL[k])) begin
        coin_idx_o = IDX_W'(k);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_manager.sv
// Vending credit manager: coin entry, credit commit, purchase, and greedy change dispense.
module credit_manager
  import vend_pkg::*;
#(
  parameter int N_COIN     = 4,
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 11,
  parameter int MAX_CREDIT = 999
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         money_mode,
  input  logic                         purchase_mode,
  input  logic                         coin_next,
  input  logic                         coin_prev,
  input  logic                         qty_valid,
  input  logic [3:0]                   qty,
  input  logic                         commit,
  input  logic                         buy_valid,
  input  logic [$clog2(N_PROD)-1:0]    buy_idx,
  input  logic [N_PROD*CREDIT_W-1:0]   price,
  input  logic [N_PROD-1:0]            stock_ok,
  input  logic                         refund,
  output logic [9:0]                   coin_sym,
  output logic [$clog2(N_COIN)-1:0]    coin_sel,
  output logic [CREDIT_W-1:0]          credit,
  output logic [CREDIT_W-1:0]          pending,
  output logic                         vend_valid,
  output logic                         buy_reject,
  output logic                         commit_reject,
  output logic [$clog2(N_PROD)-1:0]    vend_idx,
  output logic                         change_valid,
  output logic [$clog2(N_COIN)-1:0]    change_coin,
  output logic                         busy
);

  localparam int SEL_W = $clog2(N_COIN);
  localparam int IDX_W = $clog2(N_PROD);
  localparam logic [SEL_W-1:0]  SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_COIN - 1);
  localparam logic [CREDIT_W:0] MAX_SUM  = (CREDIT_W + 1)'(MAX_CREDIT);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [CREDIT_W-1:0]  pending_q, pending_d;
  logic [SEL_W-1:0]     coin_sel_q, coin_sel_d;
  logic [IDX_W-1:0]     vend_idx_q, vend_idx_d;
  logic [SEL_W-1:0]     change_coin_q, change_coin_d;
  logic                 vend_valid_q, vend_valid_d;
  logic                 buy_reject_q, buy_reject_d;
  logic                 commit_reject_q, commit_reject_d;
  logic                 change_valid_q, change_valid_d;

  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [CREDIT_W-1:0]  pick_val;
  logic [CREDIT_W-1:0]  price_sel;
  logic [CREDIT_W-1:0]  qty_amount;
  logic [CREDIT_W:0]    commit_sum;

  change_picker #(
    .N_COIN   (N_COIN),
    .CREDIT_W (CREDIT_W)
  ) u_picker (
    .credit_i   (credit_q),
    .coin_idx_o (pick_idx),
    .found_o    (pick_found)
  );

  assign pick_val   = CREDIT_W'(COIN_VAL[pick_idx]);
  assign price_sel  = price[buy_idx*CREDIT_W +: CREDIT_W];
  // qty * largest coin always fits CREDIT_W, so truncation never drops value bits.
  assign qty_amount = CREDIT_W'(int'(qty) * COIN_VAL[coin_sel_q]);
  assign commit_sum = {1'b0, credit_q} + {1'b0, pending_q};

  // Next-state and datapath decisions; IDLE events are taken in strict priority order.
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    pending_d       = pending_q;
    coin_sel_d      = coin_sel_q;
    vend_idx_d      = vend_idx_q;
    change_coin_d   = change_coin_q;
    vend_valid_d    = 1'b0;
    buy_reject_d    = 1'b0;
    commit_reject_d = 1'b0;
    change_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (refund) begin
          pending_d = '0;
          state_d   = DISPENSE;
        end else if (buy_valid && purchase_mode && !money_mode) begin
          if (stock_ok[buy_idx] && (credit_q >= price_sel)) begin
            vend_valid_d = 1'b1;
            vend_idx_d   = buy_idx;
            credit_d     = credit_q - price_sel;
            pending_d    = '0;
            state_d      = DISPENSE;
          end else begin
            buy_reject_d = 1'b1;
          end
        end else if (money_mode && commit) begin
          if (commit_sum <= MAX_SUM) begin
            credit_d = commit_sum[CREDIT_W-1:0];
          end else begin
            commit_reject_d = 1'b1;
          end
          pending_d = '0;
        end else if (money_mode && qty_valid) begin
          pending_d = qty_amount;
        end else if (money_mode && coin_next && !coin_prev) begin
          coin_sel_d = (coin_sel_q == SEL_LAST) ? '0 : coin_sel_q + SEL_ONE;
        end else if (money_mode && coin_prev && !coin_next) begin
          coin_sel_d = (coin_sel_q == '0) ? SEL_LAST : coin_sel_q - SEL_ONE;
        end
      end
      DISPENSE: begin
        // One coin per cycle; leave once the credit is below the smallest coin.
        if (pick_found) begin
          change_valid_d = 1'b1;
          change_coin_d  = pick_idx;
          credit_d       = credit_q - pick_val;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      pending_q       <= '0;
      coin_sel_q      <= '0;
      vend_idx_q      <= '0;
      change_coin_q   <= '0;
      vend_valid_q    <= 1'b0;
      buy_reject_q    <= 1'b0;
      commit_reject_q <= 1'b0;
      change_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      pending_q       <= pending_d;
      coin_sel_q      <= coin_sel_d;
      vend_idx_q      <= vend_idx_d;
      change_coin_q   <= change_coin_d;
      vend_valid_q    <= vend_valid_d;
      buy_reject_q    <= buy_reject_d;
      commit_reject_q <= commit_reject_d;
      change_valid_q  <= change_valid_d;
    end
  end

  assign coin_sym      = COIN_SYM[coin_sel_q];
  assign coin_sel      = coin_sel_q;
  assign credit        = credit_q;
  assign pending       = pending_q;
  assign vend_valid    = vend_valid_q;
  assign buy_reject    = buy_reject_q;
  assign commit_reject = commit_reject_q;
  assign vend_idx      = vend_idx_q;
  assign change_valid  = change_valid_q;
  assign change_coin   = change_coin_q;
  assign busy          = (state_q == DISPENSE);

endmodule

// File: tb/tb_credit_manager.sv
// Bench for credit_manager: directed vector table, reset corner case, random run vs reference model.
module tb_credit_manager;

  logic        clk;
  logic        rst;
  logic        money_mode, purchase_mode, coin_next, coin_prev, qty_valid;
  logic [3:0]  qty;
  logic        commit, buy_valid;
  logic [1:0]  buy_idx;
  logic [43:0] price;
  logic [3:0]  stock_ok;
  logic        refund;
  logic [9:0]  coin_sym;
  logic [1:0]  coin_sel;
  logic [10:0] credit, pending;
  logic        vend_valid, buy_reject, commit_reject;
  logic [1:0]  vend_idx;
  logic        change_valid;
  logic [1:0]  change_coin;
  logic        busy;

  credit_manager dut (
    .clk(clk), .rst(rst), .money_mode(money_mode), .purchase_mode(purchase_mode),
    .coin_next(coin_next), .coin_prev(coin_prev), .qty_valid(qty_valid), .qty(qty),
    .commit(commit), .buy_valid(buy_valid), .buy_idx(buy_idx), .price(price),
    .stock_ok(stock_ok), .refund(refund), .coin_sym(coin_sym), .coin_sel(coin_sel),
    .credit(credit), .pending(pending), .vend_valid(vend_valid), .buy_reject(buy_reject),
    .commit_reject(commit_reject), .vend_idx(vend_idx), .change_valid(change_valid),
    .change_coin(change_coin), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int VAL [4] = '{5, 10, 25, 100};
  int SYM [4] = '{16, 13, 17, 18};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    money_mode = 0; purchase_mode = 0; coin_next = 0; coin_prev = 0;
    qty_valid = 0; qty = 0; commit = 0; buy_valid = 0; buy_idx = 0; refund = 0;
  endtask

  task automatic drive(input logic mm, pm, nx, pv, qv, input int q,
                       input logic cm, bv, input int bi, input logic rf);
    money_mode = mm; purchase_mode = pm; coin_next = nx; coin_prev = pv;
    qty_valid = qv; qty = q[3:0]; commit = cm; buy_valid = bv; buy_idx = bi[1:0];
    refund = rf;
  endtask

  typedef struct {
    logic mm, pm, nx, pv, qv;
    int   q;
    logic cm, bv;
    int   bi;
    logic rf;
    int   sel, sym, cr, pd;
    logic vend, brej, crej, chv;
    int   chc;
    logic bsy;
  } vec_t;

  function automatic vec_t mk(input logic mm, pm, nx, pv, qv, input int q,
                              input logic cm, bv, input int bi, input logic rf,
                              input int sel, sym, cr, pd,
                              input logic vend, brej, crej, chv, input int chc, input logic bsy);
    vec_t v;
    v.mm = mm; v.pm = pm; v.nx = nx; v.pv = pv; v.qv = qv; v.q = q; v.cm = cm;
    v.bv = bv; v.bi = bi; v.rf = rf; v.sel = sel; v.sym = sym; v.cr = cr; v.pd = pd;
    v.vend = vend; v.brej = brej; v.crej = crej; v.chv = chv; v.chc = chc; v.bsy = bsy;
    return v;
  endfunction

  vec_t tbl [30];

  // reference model state
  int   m_cr, m_pd, m_sel, m_chc, m_vidx;
  bit   m_busy, m_vend, m_brej, m_crej, m_chv;
  int   pr [4];

  task automatic model_step();
    int k;
    m_vend = 0; m_brej = 0; m_crej = 0; m_chv = 0;
    if (m_busy) begin
      k = -1;
      for (int j = 3; j >= 0; j--) if (k < 0 && VAL[j] <= m_cr) k = j;
      if (k >= 0) begin m_chv = 1; m_chc = k; m_cr -= VAL[k]; end
      else m_busy = 0;
    end else if (refund) begin
      m_pd = 0; m_busy = 1;
    end else if (buy_valid && purchase_mode && !money_mode) begin
      if (stock_ok[buy_idx] && m_cr >= pr[buy_idx]) begin
        m_vend = 1; m_vidx = buy_idx; m_cr -= pr[buy_idx]; m_pd = 0; m_busy = 1;
      end else m_brej = 1;
    end else if (money_mode && commit) begin
      if (m_cr + m_pd <= 999) m_cr += m_pd; else m_crej = 1;
      m_pd = 0;
    end else if (money_mode && qty_valid) begin
      m_pd = int'(qty) * VAL[m_sel];
    end else if (money_mode && coin_next && !coin_prev) begin
      m_sel = (m_sel + 1) % 4;
    end else if (money_mode && coin_prev && !coin_next) begin
      m_sel = (m_sel + 3) % 4;
    end
  endtask

  initial begin
    int wait_n;
    clear_in();
    stock_ok = 4'b1011;
    price = {11'd200, 11'd50, 11'd60, 11'd20};
    rst = 1'b1;
    step(); step();
    chk("rst_credit", credit, 0);
    chk("rst_pending", pending, 0);
    chk("rst_sel", coin_sel, 0);
    chk("rst_sym", coin_sym, 16);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {vend_valid, buy_reject, commit_reject, change_valid}, 0);
    rst = 1'b0;
    step();

    //                mm pm nx pv qv q  cm bv bi rf  sel sym cr   pd   vd br cr ch chc bsy
    tbl[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 13, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  2, 17, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0,  2, 17, 0,   75,  0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  2, 17, 75,  0,   0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0,  2, 17, 15,  0,   1, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 17, 5,   0,   0, 0, 0, 1, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 17, 0,   0,   0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 17, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  3, 18, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 16, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  3, 18, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0,  3, 18, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0,  3, 18, 0,   100, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  3, 18, 100, 0,   0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 1, 2, 0,  3, 18, 100, 0,   0, 1, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  3, 18, 100, 0,   0, 0, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 18, 0,   0,   0, 0, 0, 1, 3, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 18, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 1, 2, 1, 0, 0, 0,  3, 18, 0,   0,   0, 0, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0,  3, 18, 0,   900, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  3, 18, 900, 0,   0, 0, 0, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  2, 17, 900, 0,   0, 0, 0, 0, 0, 0);
    tbl[22] = mk(1, 0, 0, 0, 1, 2, 0, 0, 0, 0,  2, 17, 900, 50,  0, 0, 0, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  2, 17, 950, 0,   0, 0, 0, 0, 0, 0);
    tbl[24] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  3, 18, 950, 0,   0, 0, 0, 0, 0, 0);
    tbl[25] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0,  3, 18, 950, 100, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  3, 18, 950, 0,   0, 0, 1, 0, 0, 0);
    tbl[27] = mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 0,  0, 16, 950, 0,   0, 0, 0, 0, 0, 0);
    tbl[28] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1,  0, 16, 950, 0,   0, 0, 0, 0, 0, 1);
    tbl[29] = mk(1, 0, 1, 0, 1, 5, 0, 0, 0, 0,  0, 16, 850, 0,   0, 0, 0, 1, 3, 1);

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].mm, tbl[i].pm, tbl[i].nx, tbl[i].pv, tbl[i].qv, tbl[i].q,
            tbl[i].cm, tbl[i].bv, tbl[i].bi, tbl[i].rf);
      step();
      chk($sformatf("v%0d_sel", i), coin_sel, tbl[i].sel);
      chk($sformatf("v%0d_sym", i), coin_sym, tbl[i].sym);
      chk($sformatf("v%0d_credit", i), credit, tbl[i].cr);
      chk($sformatf("v%0d_pending", i), pending, tbl[i].pd);
      chk($sformatf("v%0d_vend", i), vend_valid, tbl[i].vend);
      chk($sformatf("v%0d_buyrej", i), buy_reject, tbl[i].brej);
      chk($sformatf("v%0d_cmtrej", i), commit_reject, tbl[i].crej);
      chk($sformatf("v%0d_chgv", i), change_valid, tbl[i].chv);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
      if (tbl[i].chv) chk($sformatf("v%0d_chgcoin", i), change_coin, tbl[i].chc);
      if (tbl[i].vend) chk($sformatf("v%0d_vendidx", i), vend_idx, tbl[i].bi);
    end
    clear_in();

    // drain remaining 850: eight 100s, two 25s, then exit
    wait_n = 0;
    while (busy && wait_n < 20) begin step(); wait_n++; end
    chk("drain_busy", busy, 0);
    chk("drain_credit", credit, 0);
    chk("drain_cycles", wait_n, 11);

    // build 135 cents: 100 + 25 + 10
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    chk("r41_credit", credit, 135);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    clear_in();
    chk("r41_busy", busy, 1);
    step();
    chk("r41_first_chv", change_valid, 1);
    chk("r41_first_coin", change_coin, 3);
    chk("r41_after_first", credit, 35);
    #3;
    rst = 1'b1;
    #1;
    chk("r41_async_credit", credit, 0);
    chk("r41_async_pending", pending, 0);
    chk("r41_async_sel", coin_sel, 0);
    chk("r41_async_busy", busy, 0);
    chk("r41_async_chv", change_valid, 0);
    chk("r41_async_chc", change_coin, 0);
    chk("r41_async_vidx", vend_idx, 0);
    chk("r41_async_pulses", {vend_valid, buy_reject, commit_reject}, 0);
    step();
    rst = 1'b0;
    step();

    // random run against the reference model
    for (int j = 0; j < 4; j++) begin
      pr[j] = $urandom_range(5, 400);
      price[j*11 +: 11] = pr[j][10:0];
    end
    stock_ok = 4'($urandom);
    m_cr = 0; m_pd = 0; m_sel = 0; m_chc = 0; m_vidx = 0; m_busy = 0;
    for (int c = 0; c < 2000; c++) begin
      money_mode    = ($urandom % 3 == 0);
      purchase_mode = ($urandom % 2 == 0);
      coin_next     = ($urandom % 4 == 0);
      coin_prev     = ($urandom % 4 == 0);
      qty_valid     = ($urandom % 4 == 0);
      qty           = 4'($urandom);
      commit        = ($urandom % 4 == 0);
      buy_valid     = ($urandom % 3 == 0);
      buy_idx       = 2'($urandom);
      refund        = ($urandom % 25 == 0);
      model_step();
      step();
      chk("rnd_credit", credit, m_cr);
      chk("rnd_pending", pending, m_pd);
      chk("rnd_sel", coin_sel, m_sel);
      chk("rnd_sym", coin_sym, SYM[m_sel]);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_vend", vend_valid, m_vend);
      chk("rnd_buyrej", buy_reject, m_brej);
      chk("rnd_cmtrej", commit_reject, m_crej);
      chk("rnd_chgv", change_valid, m_chv);
      if (m_chv) chk("rnd_chgcoin", change_coin, m_chc);
      if (m_vend) chk("rnd_vendidx", vend_idx, m_vidx);
    end
    clear_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
